// File: rtl/jt900h_bus_ctrl.sv
// Bus controller behind the JT900H memory unit: region decode, wait states and a one-word read hold.
// Accesses take 2+W cen cycles; held-word read hits complete with no stall.
module jt900h_bus_ctrl #(
  parameter logic [23:0] IO_END     = 24'h0000FF,
  parameter logic [23:0] IRAM_START = 24'h004000,
  parameter logic [23:0] IRAM_END   = 24'h007FFF,
  parameter logic [3:0]  IO_WS      = 4'd1,
  parameter logic [3:0]  IRAM_WS    = 4'd0,
  parameter logic [3:0]  EXT_WS     = 4'd2
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [23:0] bus_addr,
  input  logic [15:0] bus_din,
  input  logic [1:0]  bus_we,
  input  logic        bus_rd,
  output logic [15:0] bus_dout,
  output logic        bus_busy,
  output logic [22:0] ext_addr,
  output logic [15:0] ext_dout,
  input  logic [15:0] ext_din,
  output logic [1:0]  ext_we,
  output logic        ext_rd,
  output logic [2:0]  ext_cs,
  input  logic        ext_wait
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      st, st_nxt;
  logic [3:0]  cnt;
  logic        hold_vld;
  logic [22:0] hold_addr;

  logic [23:0] byte_addr;
  logic        is_io, is_iram;
  logic [2:0]  cs_dec;
  logic [3:0]  ws_dec;
  logic        wr_req, rd_req, new_req, acc_done;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = bus_addr[0];
  assign byte_addr = {bus_addr[23:1], 1'b0};
  assign is_io     = byte_addr <= IO_END;
  assign is_iram   = !is_io && byte_addr >= IRAM_START && byte_addr <= IRAM_END;
  assign cs_dec    = {!is_io && !is_iram, is_iram, is_io};
  assign ws_dec    = is_io ? IO_WS : (is_iram ? IRAM_WS : EXT_WS);

  // Reads of the held word are served from bus_dout without an external cycle
  assign wr_req   = |bus_we;
  assign rd_req   = bus_rd && !wr_req && (!hold_vld || bus_addr[23:1] != hold_addr);
  assign new_req  = (st == IDLE) && (wr_req || rd_req);
  assign bus_busy = new_req || (st == ACCESS);
  assign acc_done = (st == ACCESS) && (cnt == 4'd0) && !(ext_wait && ext_cs[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else if (cen) st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (new_req) st_nxt = ACCESS;
      ACCESS:  if (acc_done) st_nxt = DONE;
      DONE:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_dout  <= 16'd0;
      ext_addr  <= 23'd0;
      ext_dout  <= 16'd0;
      ext_we    <= 2'd0;
      ext_rd    <= 1'b0;
      ext_cs    <= 3'd0;
      cnt       <= 4'd0;
      hold_vld  <= 1'b0;
      hold_addr <= 23'd0;
    end else if (cen) begin
      if (new_req) begin
        ext_addr <= bus_addr[23:1];
        ext_dout <= bus_din;
        ext_we   <= bus_we;
        ext_rd   <= !wr_req;
        ext_cs   <= cs_dec;
        cnt      <= ws_dec;
      end else if (st == ACCESS) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (acc_done) begin
          if (ext_rd) begin
            bus_dout  <= ext_din;
            hold_addr <= ext_addr;
            hold_vld  <= 1'b1;
          end else if (ext_addr == hold_addr) begin
            hold_vld <= 1'b0;
          end
          ext_cs <= 3'd0;
          ext_rd <= 1'b0;
          ext_we <= 2'd0;
        end
      end
    end
  end

endmodule
